sync_ram_sdp: RTL and testbench
===============================

# sync_ram_sdp

Parametrised simple-dual-port synchronous RAM, the next generation of the team's single-port 256x32 synchronous RAM. It provides one write port with byte enables and one independent read port with a valid flag, a selectable read-during-write policy, and an optional output register. A built-in clear engine initialises every word after reset. It is used as the generic on-chip buffer for datapath blocks that need concurrent write and read access.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address width; depth is 2**ADDR_WIDTH words.
- RDW_NEW, 0, read-during-write policy for the same address: 0 returns old data, 1 returns new (merged) data.
- OUT_REG, 0, adds an output pipeline register when 1 (read latency 2 instead of 1).
- CLEAR_VALUE, 0, DATA_WIDTH-bit word written to every location by the clear engine.

Ports:
- clk  in  1  rising-edge clock; the block has one clock.
- rst  in  1  reset, asynchronous and active-high.
- init_done  out  1  high once the clear sequence has completed.
- we  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- byte_en  in  DATA_WIDTH/8  per-byte write enable; bit i gates data_in[8i+7:8i].
- data_in  in  DATA_WIDTH  write data.
- re  in  1  read strobe.
- rd_addr  in  ADDR_WIDTH  read address.
- data_out  out  DATA_WIDTH  read data; holds its value between reads.
- rd_valid  out  1  single-cycle pulse aligned with new data_out.

## Operation
- Reset values: init_done=0, data_out=0, rd_valid=0, clear counter=0, output pipeline flushed. Array contents are not reset directly.
- Clear engine, state CLEAR:
  - Entered on reset.
  - Each cycle, writes CLEAR_VALUE to address counter, then increments the counter.
  - After writing address 2**ADDR_WIDTH-1, moves to READY and sets init_done=1.
- State READY is terminal until the next rst.
- While in CLEAR, we and re are ignored: no array write, no rd_valid.
- Write: in READY, when we=1 at a clk edge, mem[wr_addr] byte i ← data_in byte i for every byte_en[i]=1. Other bytes are unchanged. byte_en=0 means no change.
- Read: in READY, when re=1 at a clk edge, mem[rd_addr] is captured.
- Read-during-write (re=1, we=1, rd_addr==wr_addr, same edge):
  - RDW_NEW=0: data_out is the pre-write word.
  - RDW_NEW=1: data_out is the pre-write word with the enabled bytes replaced by data_in.
- Different addresses never interact.
- re=0: data_out holds its last value and rd_valid=0.

## Timing
- Clear duration: init_done rises at the end of the 2**ADDR_WIDTH-th rising edge after rst deasserts (256 edges with defaults).
- Read latency, measured from the edge sampling re=1 to the edge where data_out/rd_valid update:
  - OUT_REG=0: 1 cycle; data_out and rd_valid are valid after that edge.
  - OUT_REG=1: 2 cycles.
- Throughput is one read and one write per cycle, sustained. Back-to-back reads produce back-to-back rd_valid pulses.
- Write then read of the same address on the next cycle returns the new data regardless of RDW_NEW.
- Reset mid-clear:
  - Counter returns to 0 immediately and init_done stays 0.
  - Clear restarts from address 0 after deassertion.
- Reset mid-read:
  - Pending pipeline data is discarded and rd_valid=0 asynchronously.
  - data_out=0.
- Address wrap: the counter and addresses are modulo depth; there are no out-of-range accesses.

## Test plan
- Reset and clear with CLEAR_VALUE=32'hDEADBEEF:
  - Deassert rst and count edges: init_done=1 after exactly 256.
  - Reading addr 0, 128 and 255 returns 32'hDEADBEEF.
  - A write issued during CLEAR is lost, and re during CLEAR gives no rd_valid.
- Basic write/read:
  - Write 32'h12345678 to addr 10 and 32'hAABBCCDD to addr 20 with byte_en=4'hF.
  - Reading 10 then 20 gives 32'h12345678, then 32'hAABBCCDD, each with rd_valid one cycle after re (two with OUT_REG=1).
- Byte enables: addr 10 holds 32'h12345678; write 32'hFFFFFFFF with byte_en=4'b0101; a read returns 32'h12FF56FF.
- Read-during-write collision:
  - addr 5 holds 32'h0; on the same edge, write 32'hCAFEF00D to addr 5 and read addr 5.
  - RDW_NEW=0 gives 32'h00000000; RDW_NEW=1 gives 32'hCAFEF00D.
  - A read on the next cycle gives 32'hCAFEF00D in both modes.
- Reset mid-operation:
  - Assert rst at clear count 100: init_done=0 immediately.
  - After release, init_done rises 256 edges later, not 156.
  - Assert rst between re and rd_valid (OUT_REG=1): no rd_valid, data_out=0.
- Streaming: 256 consecutive writes of data=addr, then 256 consecutive reads at addr 0..255.
  - rd_valid stays high for 256 contiguous cycles, and data matches the address with wrap to 0.

Source files
------------

// File: rtl/sync_ram_sdp.sv
// Simple-dual-port synchronous RAM: byte-enabled write port, independent read port,
// selectable read-during-write policy, optional output register and post-reset clear.
module sync_ram_sdp #(
   parameter int unsigned            DATA_WIDTH  = 32,
   parameter int unsigned            ADDR_WIDTH  = 8,
   parameter int unsigned            RDW_NEW     = 0,
   parameter int unsigned            OUT_REG     = 0,
   parameter logic [DATA_WIDTH-1:0]  CLEAR_VALUE = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      init_done,
   input  logic                      we,
   input  logic [ADDR_WIDTH-1:0]     wr_addr,
   input  logic [DATA_WIDTH/8-1:0]   byte_en,
   input  logic [DATA_WIDTH-1:0]     data_in,
   input  logic                      re,
   input  logic [ADDR_WIDTH-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0]     data_out,
   output logic                      rd_valid
);

   localparam int unsigned DEPTH  = 2**ADDR_WIDTH;
   localparam int unsigned NBYTES = DATA_WIDTH / 8;

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_clr_addr;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

   logic                    w_ready;
   logic                    w_wr_en;
   logic [ADDR_WIDTH-1:0]   w_wr_addr;
   logic [NBYTES-1:0]       w_wr_be;
   logic [DATA_WIDTH-1:0]   w_wr_data;
   logic                    w_rd_fire;
   logic                    w_collide;
   logic [DATA_WIDTH-1:0]   w_rd_word;

   // Clear engine: sweeps every address once, then parks in READY until reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_CLEAR;
         r_clr_addr <= '0;
         init_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
               if (r_clr_addr == '1) begin
                  r_state   <= ST_READY;
                  init_done <= 1'b1;
               end
            end
            default: r_state <= ST_READY;
         endcase
      end
   end

   assign w_ready   = (r_state == ST_READY);
   assign w_wr_en   = w_ready ? we : 1'b1;
   assign w_wr_addr = w_ready ? wr_addr : r_clr_addr;
   assign w_wr_be   = w_ready ? byte_en : '1;
   assign w_wr_data = w_ready ? data_in : CLEAR_VALUE;
   assign w_rd_fire = w_ready & re;
   assign w_collide = w_ready & we & (wr_addr == rd_addr);

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (w_wr_be[b]) r_mem[w_wr_addr][8*b +: 8] <= w_wr_data[8*b +: 8];
         end
      end
   end

   // Same-address collision: optionally forward the enabled bytes of the incoming write
   always_comb begin
      w_rd_word = r_mem[rd_addr];
      if ((RDW_NEW != 0) && w_collide) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (byte_en[b]) w_rd_word[8*b +: 8] = data_in[8*b +: 8];
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_WIDTH-1:0] r_s1_data;
         logic                  r_s1_valid;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_s1_data  <= '0;
               r_s1_valid <= 1'b0;
               data_out   <= '0;
               rd_valid   <= 1'b0;
            end else begin
               r_s1_valid <= w_rd_fire;
               if (w_rd_fire) r_s1_data <= w_rd_word;
               rd_valid   <= r_s1_valid;
               if (r_s1_valid) data_out <= r_s1_data;
            end
         end
      end else begin : g_no_out_reg
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               data_out <= '0;
               rd_valid <= 1'b0;
            end else begin
               rd_valid <= w_rd_fire;
               if (w_rd_fire) data_out <= w_rd_word;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_sync_ram_sdp.sv
// Directed bench for sync_ram_sdp: one instance per policy corner
// (u0: old-data, no output reg; u1: new-data, output reg).
module tb_sync_ram_sdp;

   logic        clk;
   logic        rst;
   logic        we;
   logic [7:0]  wr_addr;
   logic [3:0]  byte_en;
   logic [31:0] data_in;
   logic        re;
   logic [7:0]  rd_addr;

   logic        init0, init1;
   logic [31:0] dout0, dout1;
   logic        vld0, vld1;

   int n_pass;
   int n_total;

   sync_ram_sdp #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RDW_NEW(0), .OUT_REG(0),
                  .CLEAR_VALUE(32'hDEADBEEF)) u0 (
      .clk(clk), .rst(rst), .init_done(init0), .we(we), .wr_addr(wr_addr),
      .byte_en(byte_en), .data_in(data_in), .re(re), .rd_addr(rd_addr),
      .data_out(dout0), .rd_valid(vld0));

   sync_ram_sdp #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RDW_NEW(1), .OUT_REG(1),
                  .CLEAR_VALUE(32'hDEADBEEF)) u1 (
      .clk(clk), .rst(rst), .init_done(init1), .we(we), .wr_addr(wr_addr),
      .byte_en(byte_en), .data_in(data_in), .re(re), .rd_addr(rd_addr),
      .data_out(dout1), .rd_valid(vld1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
      we = 1'b1; wr_addr = a; data_in = d; byte_en = be;
      tick();
      we = 1'b0; byte_en = 4'h0;
   endtask

   // Issues one read and samples each instance at its own latency
   task automatic do_read(input logic [7:0] a, input string name, input logic [31:0] exp0,
                          input logic [31:0] exp1);
      logic [31:0] d0;
      logic        v0, v1_early;
      re = 1'b1; rd_addr = a;
      tick();
      re = 1'b0;
      d0 = dout0; v0 = vld0; v1_early = vld1;
      tick();
      n_total++;
      if (v0 !== 1'b1 || d0 !== exp0)
         $display("FAIL %s u0: got valid=%b data=%h, want valid=1 data=%h", name, v0, d0, exp0);
      else n_pass++;
      n_total++;
      if (v1_early !== 1'b0 || vld1 !== 1'b1 || dout1 !== exp1)
         $display("FAIL %s u1: got early_valid=%b valid=%b data=%h, want 0/1 data=%h",
                  name, v1_early, vld1, dout1, exp1);
      else n_pass++;
      n_total++;
      if (vld0 !== 1'b0)
         $display("FAIL %s u0 pulse: got valid=%b one cycle later, want 0", name, vld0);
      else n_pass++;
   endtask

   task automatic test_reset();
      logic saw_valid;
      rst = 1'b1; we = 1'b0; re = 1'b0; wr_addr = '0; rd_addr = '0; byte_en = '0; data_in = '0;
      #1;
      n_total++;
      if (init0 !== 1'b0 || init1 !== 1'b0 || vld0 !== 1'b0 || vld1 !== 1'b0 ||
          dout0 !== 32'h0 || dout1 !== 32'h0)
         $display("FAIL reset_state: got init=%b/%b valid=%b/%b data=%h/%h, want all 0",
                  init0, init1, vld0, vld1, dout0, dout1);
      else n_pass++;
      tick();
      tick();
      rst = 1'b0;
      // Write and read held active for the whole clear; both must be ignored
      we = 1'b1; wr_addr = 8'd3; data_in = 32'h11111111; byte_en = 4'hF;
      re = 1'b1; rd_addr = 8'd0;
      saw_valid = 1'b0;
      for (int i = 0; i < 255; i++) begin
         tick();
         if (vld0 !== 1'b0 || vld1 !== 1'b0) saw_valid = 1'b1;
      end
      n_total++;
      if (init0 !== 1'b0 || init1 !== 1'b0)
         $display("FAIL clear_len_255: got init=%b/%b after 255 edges, want 0", init0, init1);
      else n_pass++;
      tick();
      if (vld0 !== 1'b0 || vld1 !== 1'b0) saw_valid = 1'b1;
      we = 1'b0; re = 1'b0; byte_en = 4'h0;
      n_total++;
      if (init0 !== 1'b1 || init1 !== 1'b1)
         $display("FAIL clear_len_256: got init=%b/%b after 256 edges, want 1", init0, init1);
      else n_pass++;
      n_total++;
      if (saw_valid !== 1'b0)
         $display("FAIL clear_read_ignored: got rd_valid during clear=%b, want 0", saw_valid);
      else n_pass++;
      tick();
      n_total++;
      if (vld0 !== 1'b0 || vld1 !== 1'b0)
         $display("FAIL clear_pipe_empty: got valid=%b/%b, want 0", vld0, vld1);
      else n_pass++;
   endtask

   task automatic test_clear_contents();
      do_read(8'd0,   "clear_addr0",   32'hDEADBEEF, 32'hDEADBEEF);
      do_read(8'd128, "clear_addr128", 32'hDEADBEEF, 32'hDEADBEEF);
      do_read(8'd255, "clear_addr255", 32'hDEADBEEF, 32'hDEADBEEF);
      do_read(8'd3,   "clear_write_lost", 32'hDEADBEEF, 32'hDEADBEEF);
   endtask

   task automatic test_basic();
      do_write(8'd10, 32'h12345678, 4'hF);
      do_write(8'd20, 32'hAABBCCDD, 4'hF);
      do_read(8'd10, "basic_addr10", 32'h12345678, 32'h12345678);
      do_read(8'd20, "basic_addr20", 32'hAABBCCDD, 32'hAABBCCDD);
   endtask

   task automatic test_byte_en();
      do_write(8'd10, 32'hFFFFFFFF, 4'b0101);
      do_read(8'd10, "byte_en_0101", 32'h12FF56FF, 32'h12FF56FF);
      do_write(8'd20, 32'h00000000, 4'b0000);
      do_read(8'd20, "byte_en_none", 32'hAABBCCDD, 32'hAABBCCDD);
   endtask

   task automatic test_rdw();
      do_write(8'd5, 32'h0, 4'hF);
      do_write(8'd6, 32'h0, 4'hF);
      we = 1'b1; wr_addr = 8'd5; data_in = 32'hCAFEF00D; byte_en = 4'hF;
      re = 1'b1; rd_addr = 8'd5;
      tick();
      we = 1'b0; re = 1'b0; byte_en = 4'h0;
      n_total++;
      if (vld0 !== 1'b1 || dout0 !== 32'h00000000)
         $display("FAIL rdw_old u0: got valid=%b data=%h, want 1 00000000", vld0, dout0);
      else n_pass++;
      tick();
      n_total++;
      if (vld1 !== 1'b1 || dout1 !== 32'hCAFEF00D)
         $display("FAIL rdw_new u1: got valid=%b data=%h, want 1 cafef00d", vld1, dout1);
      else n_pass++;
      do_read(8'd5, "rdw_next_read", 32'hCAFEF00D, 32'hCAFEF00D);
      // Partial collision: only enabled bytes are forwarded
      we = 1'b1; wr_addr = 8'd6; data_in = 32'hFFFFFFFF; byte_en = 4'b0011;
      re = 1'b1; rd_addr = 8'd6;
      tick();
      we = 1'b0; re = 1'b0; byte_en = 4'h0;
      n_total++;
      if (dout0 !== 32'h00000000)
         $display("FAIL rdw_partial u0: got %h, want 00000000", dout0);
      else n_pass++;
      tick();
      n_total++;
      if (dout1 !== 32'h0000FFFF)
         $display("FAIL rdw_partial u1: got %h, want 0000ffff", dout1);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 256; i++) begin
         we = 1'b1; wr_addr = 8'(i); data_in = 32'(i); byte_en = 4'hF;
         tick();
      end
      we = 1'b0; byte_en = 4'h0;
      for (int i = 0; i < 256; i++) begin
         re = 1'b1; rd_addr = 8'(i);
         tick();
         n_total++;
         if (vld0 !== 1'b1 || dout0 !== 32'(i))
            $display("FAIL stream u0 idx %0d: got valid=%b data=%h, want 1 %h", i, vld0, dout0, 32'(i));
         else n_pass++;
         n_total++;
         if (i == 0) begin
            if (vld1 !== 1'b0)
               $display("FAIL stream u1 first: got valid=%b, want 0", vld1);
            else n_pass++;
         end else begin
            if (vld1 !== 1'b1 || dout1 !== 32'(i - 1))
               $display("FAIL stream u1 idx %0d: got valid=%b data=%h, want 1 %h",
                        i - 1, vld1, dout1, 32'(i - 1));
            else n_pass++;
         end
      end
      re = 1'b0;
      tick();
      n_total++;
      if (vld0 !== 1'b0 || vld1 !== 1'b1 || dout1 !== 32'd255 || dout0 !== 32'd255)
         $display("FAIL stream_tail: got valid=%b/%b data=%h/%h, want 0/1 000000ff/000000ff",
                  vld0, vld1, dout0, dout1);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      re = 1'b1; rd_addr = 8'd20;
      tick();
      re = 1'b0;
      rst = 1'b1;
      #1;
      n_total++;
      if (vld1 !== 1'b0 || dout1 !== 32'h0 || dout0 !== 32'h0 || vld0 !== 1'b0 ||
          init0 !== 1'b0 || init1 !== 1'b0)
         $display("FAIL reset_mid_read: got valid=%b/%b data=%h/%h init=%b/%b, want all 0",
                  vld0, vld1, dout0, dout1, init0, init1);
      else n_pass++;
      tick();
      n_total++;
      if (vld1 !== 1'b0 || dout1 !== 32'h0)
         $display("FAIL reset_mid_read_flush: got valid=%b data=%h, want 0 0", vld1, dout1);
      else n_pass++;
      rst = 1'b0;
      for (int i = 0; i < 100; i++) tick();
      rst = 1'b1;
      #1;
      n_total++;
      if (init0 !== 1'b0 || init1 !== 1'b0)
         $display("FAIL reset_mid_clear: got init=%b/%b, want 0", init0, init1);
      else n_pass++;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 255; i++) tick();
      n_total++;
      if (init0 !== 1'b0 || init1 !== 1'b0)
         $display("FAIL restart_255: got init=%b/%b, want 0", init0, init1);
      else n_pass++;
      tick();
      n_total++;
      if (init0 !== 1'b1 || init1 !== 1'b1)
         $display("FAIL restart_256: got init=%b/%b, want 1", init0, init1);
      else n_pass++;
      do_read(8'd150, "restart_cleared", 32'hDEADBEEF, 32'hDEADBEEF);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_clear_contents();
      test_basic();
      test_byte_en();
      test_rdw();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
